// File: rtl/seq_pattern_ctrl_if.sv
// Output stream bundle of the countdown-pattern sequencer.
// master drives valid/data/line/last; slave returns ready.
interface seq_pattern_ctrl_if #(
    parameter int W  = 4,
    parameter int LW = 3
);
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] out_line;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_line,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_line,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/seq_pattern_ctrl.sv
// Countdown-pattern sequencer: emits top..1 per line, top shrinking by step.
// Ports: clk, reset (async active-low), start, abort, cfg_top/cfg_step/
// cfg_lines, out (stream master: valid/ready/data/line/last), busy, done.
module seq_pattern_ctrl #(
    parameter int W  = 4,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  cfg_top,
    input  logic [W-1:0]  cfg_step,
    input  logic [LW-1:0] cfg_lines,
    seq_pattern_ctrl_if.master out,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        LINE_END,
        DONE
    } state_t;

    localparam logic [W-1:0]  ONE  = W'(1);
    localparam logic [LW-1:0] LONE = LW'(1);

    state_t        state_q, state_d;
    logic [LW-1:0] line_q,  line_d;
    logic [LW-1:0] lines_q, lines_d;
    logic [W-1:0]  step_q,  step_d;
    logic [W-1:0]  top_q,   top_d;
    logic [W-1:0]  val_q,   val_d;

    logic emit;
    logic xfer;
    logic last_line;

    assign emit = (state_q == EMIT);
    assign xfer = emit & out.out_ready;
    // lines_q >= 1 whenever LINE_END is reachable, so no underflow
    assign last_line = (line_q == lines_q - LONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            lines_q <= '0;
            step_q  <= '0;
            top_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            lines_q <= lines_d;
            step_q  <= step_d;
            top_q   <= top_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        lines_d = lines_q;
        step_d  = step_q;
        top_d   = top_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lines_d = cfg_lines;
                    step_d  = cfg_step;
                    top_d   = cfg_top;
                    val_d   = cfg_top;
                    line_d  = '0;
                    if (cfg_lines == '0 || cfg_top == '0)
                        state_d = DONE;
                    else
                        state_d = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (val_q > ONE)
                        val_d = val_q - ONE;
                    else
                        state_d = LINE_END;
                end
            end
            LINE_END: begin
                // top <= step means the next line would start at <= 0
                if (last_line || top_q <= step_q) begin
                    state_d = DONE;
                end else begin
                    line_d  = line_q + LONE;
                    top_d   = top_q - step_q;
                    val_d   = top_q - step_q;
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && state_q != IDLE)
            state_d = IDLE;
    end

    // outputs decode from registers only; out_ready never reaches them
    assign out.out_valid = emit;
    assign out.out_data  = emit ? val_q : '0;
    assign out.out_line  = emit ? line_q : '0;
    assign out.out_last  = emit && (val_q == ONE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Scoreboard bench for seq_pattern_ctrl.
// Expected beats are queued at start and popped on each transfer.
module tb_seq_pattern_ctrl;
    localparam int W  = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  cfg_top;
    logic [W-1:0]  cfg_step;
    logic [LW-1:0] cfg_lines;
    logic          busy;
    logic          done;

    seq_pattern_ctrl_if #(.W(W), .LW(LW)) bus();

    seq_pattern_ctrl #(.W(W), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_top   (cfg_top),
        .cfg_step  (cfg_step),
        .cfg_lines (cfg_lines),
        .out       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0] sb[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out   = '0;

    task automatic check(string tag, int obs, int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] cur_out();
        return {bus.out_valid, bus.out_data, bus.out_line, bus.out_last};
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        logic [8:0] c;
        c = cur_out();
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", int'(c), int'(prev_out));
            if (done)
                done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("xfer_extra", int'(c), 0);
                end else begin
                    e = sb.pop_front();
                    check("xfer", int'(c[7:0]), int'(e));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !abort;
            prev_out   = c;
        end
    end

    task automatic push_pattern(int top, int step, int lines);
        int t;
        logic [W-1:0]  d;
        logic [LW-1:0] ln;
        t = top;
        if (lines == 0 || top == 0)
            return;
        for (int l = 0; l < lines; l++) begin
            for (int v = t; v >= 1; v--) begin
                d  = W'(v);
                ln = LW'(l);
                sb.push_back({d, ln, (v == 1)});
            end
            if (t <= step)
                break;
            t = t - step;
        end
    endtask

    // rmode 0: ready always high; 1: ready random
    task automatic run(int top, int step, int lines, int rmode,
                       int exp_cyc, bit hold);
        int base;
        int n;
        bit degen;
        degen = (lines == 0 || top == 0);
        base  = done_cnt;
        push_pattern(top, step, lines);
        cfg_top       = W'(top);
        cfg_step      = W'(step);
        cfg_lines     = LW'(lines);
        start         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start     = hold;
        cfg_top   = 4'hF;
        cfg_step  = 4'h1;
        cfg_lines = 3'h7;
        check("first_valid", int'(bus.out_valid), int'(!degen));
        check("busy_on", int'(busy), 1);
        n = 1;
        while (!done && n < 400) begin
            if (rmode == 1)
                bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("done_seen", int'(done), 1);
        if (exp_cyc > 0)
            check("cycles", n, exp_cyc);
        start = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("busy_off", int'(busy), 0);
        check("done_once", done_cnt - base, 1);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int n;
        int base;
        reset         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_top       = '0;
        cfg_step      = '0;
        cfg_lines     = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out", int'(cur_out()), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        tick();

        run(9, 2, 4, 0, 29, 1'b0);
        run(9, 2, 4, 1, -1, 1'b0);
        run(5, 3, 4, 0, 10, 1'b0);
        run(9, 2, 0, 0, 1, 1'b0);
        run(0, 2, 4, 0, 1, 1'b0);
        run(3, 1, 2, 0, 8, 1'b1);
        run(2, 0, 3, 0, 10, 1'b0);

        // abort in the middle of line 1
        push_pattern(9, 2, 4);
        cfg_top = 4'd9; cfg_step = 4'd2; cfg_lines = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(bus.out_valid && bus.out_line == 3'd1 &&
                 bus.out_data == 4'd5) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach", int'(bus.out_line), 1);
        base  = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", int'(bus.out_valid), 0);
        check("abort_busy", int'(busy), 0);
        sb.delete();
        tick();
        tick();
        check("abort_nodone", done_cnt - base, 0);

        // abort during the bubble between lines
        push_pattern(3, 1, 3);
        cfg_top = 4'd3; cfg_step = 4'd1; cfg_lines = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(busy && !bus.out_valid && !done) && n < 100) begin
            tick();
            n++;
        end
        check("le_reach", int'(busy && !bus.out_valid), 1);
        base  = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("le_abort_busy", int'(busy), 0);
        sb.delete();
        tick();
        tick();
        check("le_abort_nodone", done_cnt - base, 0);

        run(9, 2, 4, 0, 29, 1'b0);

        // reset while stalled in EMIT
        push_pattern(9, 2, 4);
        cfg_top = 4'd9; cfg_step = 4'd2; cfg_lines = 3'd4;
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("stall_data", int'(cur_out()),
              int'({1'b1, 4'd9, 3'd0, 1'b0}));
        #2;
        reset = 1'b0;
        #1;
        check("arst_out", int'(cur_out()), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        sb.delete();
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        run(9, 2, 4, 0, 29, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
